// File: rtl/ccff_chain_loader_if.sv
// Word-wide bitstream stream feeding the CCFF chain loader.
// The source drives data/valid; the loader returns ready.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// CCFF chain writer: clears the chain, proves its length with a single-one
// probe, then serializes the upstream bitstream LSB first into ccff_head.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic               prog_clock,
  input  logic               global_reset,
  input  logic               start,
  ccff_chain_loader_if.slave cfg,
  output logic               config_enable,
  output logic               ccff_head,
  input  logic               ccff_tail,
  output logic               busy,
  output logic               done,
  output logic               error
);
  localparam int CW = $clog2(CHAIN_LEN + 2);
  localparam int BW = $clog2(WORD_W + 1);
  localparam int MW = (CW > BW) ? CW : BW;
  localparam logic [CW-1:0] LEN  = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
  localparam logic [BW-1:0] WBITS = BW'(WORD_W);

  typedef enum logic [2:0] {IDLE, CLEAR, PROBE, LOAD, FINISH} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt, left;
  logic [WORD_W-1:0] sreg, sreg_nxt;
  logic [BW-1:0]     sbits, sbits_nxt;
  logic              en_nxt, head_nxt, ready_nxt, busy_nxt, done_nxt, error_nxt;
  logic              take;

  assign take = cfg.cfg_ready & cfg.cfg_valid;
  assign left = LEN - cnt;

  always_ff @(posedge prog_clock or posedge global_reset) begin
    if (global_reset) begin
      state         <= IDLE;
      cnt           <= '0;
      sreg          <= '0;
      sbits         <= '0;
      config_enable <= 1'b0;
      ccff_head     <= 1'b0;
      cfg.cfg_ready <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      sreg          <= sreg_nxt;
      sbits         <= sbits_nxt;
      config_enable <= en_nxt;
      ccff_head     <= head_nxt;
      cfg.cfg_ready <= ready_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      error         <= error_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    sbits_nxt = sbits;
    en_nxt    = 1'b0;
    head_nxt  = 1'b0;
    ready_nxt = 1'b0;
    busy_nxt  = 1'b1;
    done_nxt  = 1'b0;
    error_nxt = error;
    unique case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
          error_nxt = 1'b0;
          en_nxt    = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      CLEAR: begin
        en_nxt = 1'b1;
        if (cnt == LAST) begin
          state_nxt = PROBE;
          cnt_nxt   = '0;
          head_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PROBE: begin
        // The marker must surface on the tail in probe cycle CHAIN_LEN and no earlier.
        if (ccff_tail != (cnt == LEN)) begin
          error_nxt = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = FINISH;
        end else if (cnt == LEN) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
          sbits_nxt = '0;
          ready_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
          en_nxt  = 1'b1;
        end
      end
      LOAD: begin
        // cnt counts bits already issued to the head; the last one shifts in this cycle.
        if (cnt == LEN) begin
          state_nxt = FINISH;
          done_nxt  = 1'b1;
        end else begin
          if (sbits != '0) begin
            head_nxt  = sreg[0];
            sreg_nxt  = sreg >> 1;
            sbits_nxt = sbits - BW'(1);
            en_nxt    = 1'b1;
            cnt_nxt   = cnt + CW'(1);
          end else if (take) begin
            head_nxt  = cfg.cfg_data[0];
            sreg_nxt  = cfg.cfg_data >> 1;
            // Bits of the last word past the chain end are dropped here.
            if (MW'(left) >= MW'(WORD_W)) sbits_nxt = WBITS - BW'(1);
            else                          sbits_nxt = BW'(left) - BW'(1);
            en_nxt    = 1'b1;
            cnt_nxt   = cnt + CW'(1);
          end
          ready_nxt = (sbits_nxt == '0) && (cnt_nxt != LEN);
        end
      end
      FINISH: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: behavioural CCFF chain model plus a
// scoreboard of per-sequence expectations checked on each done pulse.
module tb_ccff_chain_loader;
  localparam int L = 12;
  localparam int W = 8;

  logic prog_clock = 1'b0;
  logic global_reset, start, config_enable, ccff_head, ccff_tail, busy, done, error;

  ccff_chain_loader_if #(.WORD_W(W)) cfg();

  ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .prog_clock    (prog_clock),
    .global_reset  (global_reset),
    .start         (start),
    .cfg           (cfg),
    .config_enable (config_enable),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 prog_clock = ~prog_clock;

  // Chain model: stage 0 next to the head, stage chain_n-1 drives the tail.
  logic [15:0] chain = '1;
  int          chain_n = L;
  bit          broken = 1'b0;
  always @(posedge prog_clock) if (config_enable) chain <= {chain[14:0], ccff_head};
  assign ccff_tail = broken ? 1'b0 : chain[chain_n-1];

  int cyc = 0, en_tot = 0, acc_tot = 0, rdy_tot = 0;
  always @(posedge prog_clock) cyc <= cyc + 1;
  always @(negedge prog_clock) begin
    if (config_enable) en_tot <= en_tot + 1;
    if (cfg.cfg_valid && cfg.cfg_ready) acc_tot <= acc_tot + 1;
    if (cfg.cfg_ready) rdy_tot <= rdy_tot + 1;
  end

  typedef struct {
    int           done_at;
    bit           err;
    int           en;
    int           words;
    bit           rdy;
    logic [L-1:0] chain;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [W-1:0] d, input int gap);
    int n, t;
    bit sent;
    n = 0; t = 0; sent = 0;
    while (!sent && t < 100) begin
      @(negedge prog_clock); t++;
      if (n < gap) begin
        if (cfg.cfg_ready) n++;
      end else begin
        cfg.cfg_data  = d;
        cfg.cfg_valid = 1'b1;
        if (cfg.cfg_ready) begin
          @(posedge prog_clock); #1;
          cfg.cfg_valid = 1'b0;
          cfg.cfg_data  = '0;
          sent = 1'b1;
        end
      end
    end
    if (!sent) begin
      cfg.cfg_valid = 1'b0;
      chk("send_timeout", 0, 1);
    end
  endtask

  task automatic run_seq(input string tag, input int n, input bit brk,
                         input logic [W-1:0] w0, input logic [W-1:0] w1,
                         input int gap, input bit pokes);
    exp_t e, g;
    int   s_cyc, s_en, s_acc, s_rdy, t;
    bit   seen, pass;
    pass = !brk && (n == L);
    chain_n = n;
    broken  = brk;
    e.err   = !pass;
    // Pass: 12 clear + 13 probe + 1 fetch + 12 shifts; done seen 38 edges after start.
    if (pass)     e.done_at = 38 + gap;
    else if (brk) e.done_at = L + L + 1;
    else          e.done_at = L + n + 1;
    // Failing runs keep enable high on every cycle up to FINISH.
    e.en    = pass ? (L + L + 1 + L) : e.done_at;
    e.words = pass ? 2 : 0;
    e.rdy   = pass;
    for (int i = 0; i < L; i++) begin
      if (i < W) e.chain[L-1-i] = w0[i];
      else       e.chain[L-1-i] = w1[i-W];
    end
    sb.push_back(e);

    @(negedge prog_clock);
    s_cyc = cyc + 1; s_en = en_tot; s_acc = acc_tot; s_rdy = rdy_tot;
    start = 1'b1;
    @(negedge prog_clock);
    start = 1'b0;
    fork
      begin
        if (pass) begin
          send_word(w0, 0);
          send_word(w1, gap);
        end else begin
          cfg.cfg_data  = '1;
          cfg.cfg_valid = 1'b1;
        end
      end
      begin
        if (pokes) begin
          repeat (4) @(negedge prog_clock);
          start = 1'b1;
          @(negedge prog_clock); start = 1'b0;
          repeat (23) @(negedge prog_clock);
          start = 1'b1;
          @(negedge prog_clock); start = 1'b0;
        end
      end
    join_none

    seen = 1'b0; t = 0;
    while (!seen && t < 200) begin
      @(negedge prog_clock); t++;
      if (done) seen = 1'b1;
    end
    g = sb.pop_front();
    if (!seen) begin
      chk($sformatf("%s.done_timeout", tag), 0, 1);
    end else begin
      chk($sformatf("%s.done_cycle", tag), cyc - s_cyc, g.done_at);
      chk($sformatf("%s.error", tag), error, g.err);
      chk($sformatf("%s.enable_cycles", tag), en_tot - s_en, g.en);
      chk($sformatf("%s.words", tag), acc_tot - s_acc, g.words);
      chk($sformatf("%s.ready_seen", tag), (rdy_tot - s_rdy) > 0, g.rdy);
      if (!g.err) chk($sformatf("%s.chain", tag), chain[L-1:0], g.chain);
    end
    cfg.cfg_valid = 1'b0;
    @(negedge prog_clock);
    chk($sformatf("%s.done_pulse", tag), done, 0);
    chk($sformatf("%s.idle_busy", tag), busy, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk($sformatf("%s.busy", tag), busy, 0);
    chk($sformatf("%s.enable", tag), config_enable, 0);
    chk($sformatf("%s.ready", tag), cfg.cfg_ready, 0);
    chk($sformatf("%s.head", tag), ccff_head, 0);
    chk($sformatf("%s.done", tag), done, 0);
    chk($sformatf("%s.error", tag), error, 0);
  endtask

  initial begin
    global_reset  = 1'b1;
    start         = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_data  = '0;
    repeat (2) @(negedge prog_clock);
    chk_reset_vals("por");
    global_reset = 1'b0;

    run_seq("nominal",    L,  1'b0, 8'hA5, 8'h3C, 0, 1'b0);
    run_seq("stall",      L,  1'b0, 8'hA5, 8'h3C, 5, 1'b0);
    run_seq("busy_start", L,  1'b0, 8'hA5, 8'h3C, 0, 1'b1);
    run_seq("short",      11, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    run_seq("broken",     L,  1'b1, 8'h00, 8'h00, 0, 1'b0);

    // error stays set in IDLE until reset or the next start
    repeat (3) @(negedge prog_clock);
    chk("sticky_error", error, 1);
    global_reset = 1'b1; #1;
    chk("idle_reset_error", error, 0);
    @(negedge prog_clock);
    global_reset = 1'b0;

    // Reset in the middle of LOAD, with the second word still pending.
    chain_n = L; broken = 1'b0;
    @(negedge prog_clock); start = 1'b1;
    @(negedge prog_clock); start = 1'b0;
    send_word(8'h5A, 0);
    repeat (5) @(negedge prog_clock);
    chk("midload_busy_before", busy, 1);
    global_reset = 1'b1; #1;
    chk_reset_vals("midload_reset");
    @(negedge prog_clock);
    global_reset = 1'b0;

    run_seq("after_reset", L, 1'b0, 8'h96, 8'h07, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain controller for the configuration flip-flop (CCFF) chain. It drives the chain head and watches the chain tail, both on `prog_clock`, so it is the writer side of the chain that the tile-level `RS_CCFF` memories read. On each `start` it runs three passes. First it clears the chain to zeros. Then it probes the chain with a single-one marker to prove the chain length is exactly `CHAIN_LEN`. Finally it serializes a word-wide bitstream from an upstream valid/ready source into `ccff_head`, with `config_enable` asserted only while bits are actually moving.

## Interface
Parameters:
- `CHAIN_LEN`, default 64: number of CCFF stages between `ccff_head` and `ccff_tail`; must be ≥ 2.
- `WORD_W`, default 8: width of the bitstream input word; must be ≥ 1.

Ports:
- `prog_clock`, input, 1: the single clock; every register samples on its rising edge.
- `global_reset`, input, 1: reset, asynchronous and active-high.
- `start`, input, 1: one-cycle request to begin a sequence; it is ignored while `busy` is high.
- `cfg_data`, input, `WORD_W`: bitstream word; bit 0 is shifted first.
- `cfg_valid`, input, 1: `cfg_data` is valid.
- `cfg_ready`, output, 1: the loader accepts the word on this edge when `cfg_valid` is also high.
- `config_enable`, output, 1: chain shift enable, fed to every CCFF stage.
- `ccff_head`, output, 1: serial data into the first stage.
- `ccff_tail`, input, 1: serial data out of the last stage.
- `busy`, output, 1: a sequence is in progress.
- `done`, output, 1: one-cycle pulse at the end of a sequence, whether it passed or failed.
- `error`, output, 1: sticky chain-length fault; cleared on the next accepted `start`.

## Operation
- The block has five states: IDLE, CLEAR, PROBE, LOAD and FINISH.
- IDLE:
  - `busy`, `config_enable` and `cfg_ready` are all 0.
  - Accepting `start` clears `error`, zeroes the bit counter and moves to CLEAR.
- CLEAR:
  - `config_enable` = 1 and `ccff_head` = 0 for exactly `CHAIN_LEN` cycles, then the state moves to PROBE.
- PROBE:
  - `config_enable` = 1 throughout.
  - `ccff_head` = 1 in probe cycle 0 and 0 in every later probe cycle.
  - `ccff_tail` is sampled on every edge. It must read 0 in probe cycles 0 through `CHAIN_LEN`−1 and 1 in probe cycle `CHAIN_LEN`.
  - If the tail is 1 earlier than cycle `CHAIN_LEN`, the chain is short.
  - If the tail is 0 at cycle `CHAIN_LEN`, the chain is long or broken.
  - On either failure: set `error` and go to FINISH without entering LOAD.
  - On a pass, go to LOAD.
- LOAD:
  - The loader needs ceil(`CHAIN_LEN`/`WORD_W`) words.
  - `cfg_ready` = 1 only when the word shift register is empty and bits remain to load.
  - An accepted word is shifted out LSB first, one bit per cycle, on `ccff_head`, with `config_enable` = 1.
  - Upper bits of the final word beyond `CHAIN_LEN` total bits are discarded and never driven with enable high.
  - The first bit shifted in ends up in the last stage, nearest the tail.
- Starvation: when the shift register is empty and `cfg_valid` = 0, `config_enable` drops to 0 and the chain holds its contents. Shifting resumes in the cycle after the next word is accepted.
- Exit from LOAD: after exactly `CHAIN_LEN` enabled shifts, go to FINISH.
- FINISH:
  - `done` = 1 for one cycle and `config_enable` = 0.
  - The next state is IDLE.
- Counter width is clog2(`CHAIN_LEN`+2). The counter is reused by CLEAR, PROBE and LOAD and is zeroed on every state entry.

## Timing
- Reset values: `cfg_ready` = 0, `config_enable` = 0, `ccff_head` = 0, `busy` = 0, `done` = 0, `error` = 0; state = IDLE.
- All outputs are registered.
- Start latency: `start` sampled high at edge *t* puts `busy` and `config_enable` at 1 from edge *t*+1.
- Chain latency: a bit driven on `ccff_head` in cycle *k* with enable high appears on `ccff_tail` in cycle *k*+`CHAIN_LEN` (counting enabled cycles only).
- Passing sequence length: `CHAIN_LEN` (CLEAR) + `CHAIN_LEN`+1 (PROBE) + `CHAIN_LEN` (LOAD, no stalls) + 1 (FINISH).
- Handshake:
  - A transfer happens on an edge where `cfg_valid` and `cfg_ready` are both 1.
  - `cfg_ready` never depends combinationally on `cfg_valid`.
  - `cfg_data` is captured only on the transfer edge.
- Reset mid-sequence: the asynchronous return to IDLE and reset values above applies immediately.
  - No pending word is retained.
  - The chain contents are undefined and the next `start` rebuilds them.
- If `start` arrives while in FINISH it is ignored; `start` is honoured only in IDLE.

## Test plan
Parameters for all scenarios: `CHAIN_LEN` = 12, `WORD_W` = 8. The bench models the chain as a 12-stage shift register enabled by `config_enable`.
- Reset: assert `global_reset` mid-LOAD.
  - Required: all outputs at reset values at once; a new `start` completes normally.
- Nominal load: words 0xA5 and 0x3C presented back-to-back.
  - Required: chain holds bits 0xA5 then 0xC (the low nibble of 0x3C, LSB first); `done` pulses at cycle 38 after `start`; `error` = 0.
- Stall: `cfg_valid` held low for 5 cycles between the two words.
  - Required: `config_enable` low for exactly those cycles; final chain contents identical to the nominal case; `done` arrives 5 cycles later.
- Short chain: model with 11 stages.
  - Required: tail reads 1 at probe cycle 11; `error` = 1; `done` pulses; `cfg_ready` never asserted.
- Broken chain: tail tied to 0.
  - Required: `error` = 1 at probe cycle 12; no words consumed.
- Start while busy: `start` pulsed during CLEAR and again during LOAD.
  - Required: both ignored; sequence timing unchanged.
